lsu_stage: RTL
==============

Name: lsu_stage

Overview:
- Parametrised load/store unit for the ARVI memory-access stage.
- Drives the data-memory port through a req/ack handshake and retires stores into a SB_DEPTH-entry store buffer, so stores never stall the pipe unless the buffer is full.
- Performs misalignment checks, byte-enable generation, load-data extraction and sign extension.
- Sits between the execute stage and write-back; its exception outputs feed the CSR unit.

Parameters:
XLEN, 32, datapath width; 32 or 64 (64 enables LD/SD/LWU via f3)
SB_DEPTH, 4, store-buffer entries; power of two, >=2

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-low
i_valid  in  1  valid instruction present in stage
i_memread  in  1  load
i_memwrite  in  1  store
i_f3  in  3  funct3 (size/sign)
i_addr  in  XLEN  effective address (ALU result)
i_wr_data  in  XLEN  store data, LSB-aligned
i_flush  in  1  kill current instruction (later-stage exception/eret)
o_rd  out  XLEN  load result, extended
o_rd_valid  out  1  o_rd valid this cycle
o_stall  out  1  hold upstream stages
o_ex_ld  out  1  load address misaligned
o_ex_st  out  1  store address misaligned
o_badaddr  out  XLEN  faulting address
o_sb_empty  out  1  store buffer empty (for FENCE)
o_mem_req  out  1  memory request
o_mem_we  out  1  write request
o_mem_addr  out  XLEN  word-aligned (XLEN/8) address
o_mem_wdata  out  XLEN  lane-positioned write data
o_mem_be  out  XLEN/8  byte enables
i_mem_ack  in  1  request accepted/completed; read data valid same cycle
i_mem_rdata  in  XLEN  read data

Behaviour:
- Reset (i_rst=0 at clock edge): store buffer empty, FSM IDLE, all outputs 0, o_sb_empty=1.
- Misalignment, combinational, only when i_valid & ~i_flush:
  - half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0.
  - Asserts o_ex_ld or o_ex_st with o_badaddr=i_addr.
  - No enqueue, no memory op, no stall. Otherwise o_badaddr=0.
- Store (aligned, i_valid & i_memwrite & ~i_flush):
  - Enqueue {aligned addr, shifted data, BE} at the clock edge; zero latency, no stall.
  - If the buffer is full, o_stall=1. A pop in the same cycle frees a slot and the store enqueues that cycle.
- Drain:
  - FSM IDLE->ST_REQ when the buffer is non-empty and no load is pending.
  - In ST_REQ, o_mem_req/we/addr/wdata/be hold stable until i_mem_ack; on ack, pop the head and return to IDLE.
- Load (aligned, i_valid & i_memread & ~i_flush):
  - If any valid buffer entry has the same aligned address, o_stall=1 until no entry matches. No forwarding.
  - Otherwise the load takes priority over starting a drain, but never preempts an in-flight ST_REQ.
  - IDLE->LD_REQ: o_stall=1, request held until i_mem_ack.
  - On ack: extract lane by addr low bits, sign- or zero-extend per f3, register into o_rd, then go to LD_DONE.
  - LD_DONE (1 cycle): o_stall=0, o_rd_valid=1, o_rd stable. The instruction still presented is treated as complete, so no re-issue. Then IDLE.
- Minimum load latency: 2 cycles from issue to o_rd_valid, with ack in the first request cycle.
- Flush:
  - i_flush blocks enqueue and load issue that cycle.
  - Flush during LD_REQ: the request is kept until ack (handshake is never abandoned), the data is discarded, no o_rd_valid is produced, and the FSM returns to IDLE.
  - Buffered stores are committed and never flushed.
- Ordering: stores drain in FIFO order. Pointers wrap modulo SB_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Reset mid-transaction: the FSM returns to IDLE immediately and the buffer clears. The memory side must also be reset.
- o_sb_empty=1 iff the buffer is empty and the FSM is not in ST_REQ.

Test Plan:
- Reset, then SW 0xDEADBEEF @0x100 and SB 0x5A @0x203, with ack after 2 cycles: no stall on either store. Memory sees 0x100/BE=1111 then 0x200/BE=1000 with wdata 0x5A000000. o_sb_empty returns to 1.
- Fill buffer with 5 stores, memory ack held low: o_stall asserts on the 5th store until the first ack, and the 5th store enqueues in the pop cycle.
- LB @0x102 with rdata 0x00800000 gives o_rd=0xFFFFFF80. LBU gives 0x00000080. o_rd_valid pulses in the cycle after ack.
- SW @0x40 pending (ack delayed 3 cycles), then LW @0x40: the load stalls until the store pops, then reads. A concurrent LW @0x80 issues only after the in-flight ST_REQ completes.
- LH @0x101 gives o_ex_ld=1, o_badaddr=0x101, no o_mem_req. SW @0x102 gives o_ex_st=1, no enqueue.
- Issue LW, then assert i_flush in LD_REQ with ack 2 cycles later: the request stays stable until ack and no o_rd_valid is produced. Separately, drive i_rst=0 during ST_REQ: o_sb_empty=1 next cycle.

Source files
------------

// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit with FIFO store buffer, misalignment checks and req/ack data-memory port
module lsu_stage #(
  parameter int XLEN = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_memread,
  input  logic              i_memwrite,
  input  logic [2:0]        i_f3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wr_data,
  input  logic              i_flush,
  output logic [XLEN-1:0]   o_rd,
  output logic              o_rd_valid,
  output logic              o_stall,
  output logic              o_ex_ld,
  output logic              o_ex_st,
  output logic [XLEN-1:0]   o_badaddr,
  output logic              o_sb_empty,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_be,
  input  logic              i_mem_ack,
  input  logic [XLEN-1:0]   i_mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int PW = $clog2(SB_DEPTH);
  typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_DONE} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] sb_addr [SB_DEPTH];
  logic [XLEN-1:0] sb_data [SB_DEPTH];
  logic [NB-1:0] sb_be [SB_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, cnt;
  logic [XLEN-1:0] a_al, ld_addr, sh, mask, ext;
  logic [2:0] ld_f3;
  logic ld_kill, misal, ld_ok, st_ok, hit, full, empty, pop, push, sbit;

  function automatic logic [NB-1:0] be_of(input logic [1:0] sz, input logic [OB-1:0] off);
    logic [NB-1:0] m;
    m = sz == 2'd0 ? NB'(1) : sz == 2'd1 ? NB'(3) : sz == 2'd2 ? NB'(15) : '1;
    return m << off;
  endfunction

  assign a_al = {i_addr[XLEN-1:OB], {OB{1'b0}}};
  assign misal = i_valid & ~i_flush & (i_memread | i_memwrite) &
                 (i_f3[1:0] == 2'd1 ? i_addr[0] : i_f3[1:0] == 2'd2 ? |i_addr[1:0] :
                  i_f3[1:0] == 2'd3 ? |i_addr[2:0] : 1'b0);
  assign ld_ok = i_valid & i_memread & ~i_flush & ~misal;
  assign st_ok = i_valid & i_memwrite & ~i_flush & ~misal;
  assign cnt = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW] != rd_ptr[PW]) & (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop = (state == ST_REQ) & i_mem_ack;
  assign o_stall = (state == LD_REQ) | (ld_ok & (state != LD_DONE)) | (st_ok & full & ~pop);
  assign push = st_ok & ~o_stall;
  assign o_ex_ld = misal & i_memread;
  assign o_ex_st = misal & i_memwrite;
  assign o_badaddr = misal ? i_addr : '0;
  assign o_rd_valid = state == LD_DONE;
  assign o_sb_empty = empty & (state != ST_REQ);
  assign o_mem_req = (state == ST_REQ) | (state == LD_REQ);
  assign o_mem_we = state == ST_REQ;
  assign o_mem_addr = state == ST_REQ ? sb_addr[rd_ptr[PW-1:0]] :
                      state == LD_REQ ? {ld_addr[XLEN-1:OB], {OB{1'b0}}} : '0;
  assign o_mem_wdata = state == ST_REQ ? sb_data[rd_ptr[PW-1:0]] : '0;
  assign o_mem_be = state == ST_REQ ? sb_be[rd_ptr[PW-1:0]] :
                    state == LD_REQ ? be_of(ld_f3[1:0], ld_addr[OB-1:0]) : '0;

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++)
      hit = hit | (((PW+1)'(k) < cnt) && (sb_addr[rd_ptr[PW-1:0] + PW'(k)] == a_al));
  end

  always_comb begin
    sh = i_mem_rdata >> {ld_addr[OB-1:0], 3'b000};
    mask = ld_f3[1:0] == 2'd0 ? XLEN'(8'hff) : ld_f3[1:0] == 2'd1 ? XLEN'(16'hffff) :
           ld_f3[1:0] == 2'd2 ? XLEN'(32'hffff_ffff) : '1;
    sbit = ld_f3[1:0] == 2'd0 ? sh[7] : ld_f3[1:0] == 2'd1 ? sh[15] :
           ld_f3[1:0] == 2'd2 ? sh[31] : sh[XLEN-1];
    ext = (sh & mask) | ({XLEN{sbit & ~ld_f3[2]}} & ~mask);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = ld_ok & ~hit ? LD_REQ : ~empty ? ST_REQ : IDLE;
      ST_REQ:  state_nx = i_mem_ack ? IDLE : ST_REQ;
      LD_REQ:  state_nx = ~i_mem_ack ? LD_REQ : (ld_kill | i_flush) ? IDLE : LD_DONE;
      LD_DONE: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ld_kill <= 1'b0;
      ld_addr <= '0;
      ld_f3 <= '0;
      o_rd <= '0;
    end else begin
      state <= state_nx;
      ld_kill <= (state == LD_REQ) & ~i_mem_ack & (ld_kill | i_flush);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if ((state == IDLE) & ld_ok & ~hit) begin
        ld_addr <= i_addr;
        ld_f3 <= i_f3;
      end
      if ((state == LD_REQ) & i_mem_ack & ~ld_kill & ~i_flush) o_rd <= ext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      sb_addr[wr_ptr[PW-1:0]] <= a_al;
      sb_data[wr_ptr[PW-1:0]] <= i_wr_data << {i_addr[OB-1:0], 3'b000};
      sb_be[wr_ptr[PW-1:0]] <= be_of(i_f3[1:0], i_addr[OB-1:0]);
    end
  end
endmodule
